// File: rtl/risc16_mmio_pkg.sv
// risc16_mmio_pkg: register offsets, STATUS bit indices and UART FSM state type for the MMIO UART
package risc16_mmio_pkg;
  localparam logic [2:0] OFF_TXDATA = 3'd0;
  localparam logic [2:0] OFF_STATUS = 3'd2;
  localparam logic [2:0] OFF_DIV    = 3'd4;
  localparam logic [2:0] OFF_CTRL   = 3'd6;
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
endpackage

// File: rtl/mmio_byte_fifo.sv
// mmio_byte_fifo: synchronous byte FIFO with push/pop/full/empty/count, async active-high reset
// Ports: clk, rst, push/din, pop/dout (head byte, combinational), full, empty, count.
module mmio_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rp];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/risc16_mmio_uart_tx.sv
// risc16_mmio_uart_tx: memory-mapped 8N1 UART transmitter with byte FIFO on the risc16b data port
// Ports: clk, rst (async, active-high), d_addr/d_oe/d_we/d_dout from the core, rdata/hit back to
// the d_din mux, txd serial out; irq exists only when RISC16_UART_IRQ_EN is defined.
module risc16_mmio_uart_tx
  import risc16_mmio_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'hFF00,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] d_addr,
  input  logic        d_oe,
  input  logic [1:0]  d_we,
  input  logic [15:0] d_dout,
  output logic [15:0] rdata,
  output logic        hit,
  output logic        txd
`ifdef RISC16_UART_IRQ_EN
  ,
  output logic        irq
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  uart_state_t state;
  logic [7:0] shift, fifo_dout;
  logic [2:0] bitcnt;
  logic [15:0] div, div_q, div_l, cnt, status, ctrl_rd;
  logic [CW-1:0] count;
  logic [1:0] off;
  logic full, empty, ovf, wr, push, pop, tick, busy, unused_sig;
  assign unused_sig = &{1'b0, d_oe, d_addr[0]};
  assign hit = d_addr[15:3] == BASE_ADDR[15:3];
  assign off = d_addr[2:1];
  assign wr = hit && |d_we;
  assign push = wr && off == OFF_TXDATA[2:1];
  assign busy = state != IDLE;
  assign tick = cnt == '0;
  // a new frame can start from IDLE or straight out of the last STOP cycle
  assign pop = !empty && (state == IDLE || (state == STOP && tick));
  assign div_l = div == '0 ? 16'd1 : div;
  assign txd = state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
  assign status = {8'(count), 4'b0, ovf, busy, full, empty};
  assign rdata = !hit ? 16'h0 : off == OFF_STATUS[2:1] ? status : off == OFF_DIV[2:1] ? div : off == OFF_CTRL[2:1] ? ctrl_rd : 16'h0;
  mmio_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .din(d_we[1] ? d_dout[7:0] : d_dout[15:8]),
    .pop(pop),
    .dout(fifo_dout),
    .full(full),
    .empty(empty),
    .count(count)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      div <= DEFAULT_DIV;
      ovf <= 1'b0;
    end else begin
      if (push && full) ovf <= 1'b1;
      else if (wr && off == OFF_STATUS[2:1]) ovf <= 1'b0;
      if (wr && off == OFF_DIV[2:1]) begin
        if (d_we[0]) div[15:8] <= d_dout[15:8];
        if (d_we[1]) div[7:0] <= d_dout[7:0];
      end
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      shift <= '0;
      bitcnt <= '0;
      cnt <= '0;
      div_q <= 16'd1;
    end else if (pop) begin
      shift <= fifo_dout;
      div_q <= div_l;
      cnt <= div_l - 16'd1;
      bitcnt <= 3'd7;
      state <= START;
    end else if (busy) begin
      cnt <= tick ? div_q - 16'd1 : cnt - 16'd1;
      if (tick)
        case (state)
          START: state <= DATA;
          DATA: begin
            shift <= shift >> 1;
            bitcnt <= bitcnt - 3'd1;
            if (bitcnt == '0) state <= STOP;
          end
          default: state <= IDLE;
        endcase
    end
`ifdef RISC16_UART_IRQ_EN
  logic irq_en;
  assign ctrl_rd = {15'b0, irq_en};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      irq_en <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (wr && off == OFF_CTRL[2:1] && d_we[1]) irq_en <= d_dout[0];
      irq <= irq_en && empty && !busy;
    end
`else
  assign ctrl_rd = 16'h0;
`endif
endmodule

// File: tb/tb_risc16_mmio_uart_tx.sv
// tb_risc16_mmio_uart_tx: table-driven register checks plus hand-written serial frame sequences
module tb_risc16_mmio_uart_tx;
  import risc16_mmio_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] d_addr = '0, d_dout = '0;
  logic [1:0] d_we = '0;
  logic d_oe = 1'b0;
  logic [15:0] rdata;
  logic hit, txd;
`ifdef RISC16_UART_IRQ_EN
  logic irq;
  localparam logic [15:0] CTRL_EXP = 16'h0001;
`else
  localparam logic [15:0] CTRL_EXP = 16'h0000;
`endif
  int checks = 0, errors = 0;
  typedef struct {
    logic [15:0] addr;
    logic [1:0]  we;
    logic [15:0] dout;
    logic [15:0] exp;
    logic        exp_hit;
  } vec_t;
  vec_t vecs[12];
  always #5 clk = ~clk;
  risc16_mmio_uart_tx dut (
    .clk(clk),
    .rst(rst),
    .d_addr(d_addr),
    .d_oe(d_oe),
    .d_we(d_we),
    .d_dout(d_dout),
    .rdata(rdata),
    .hit(hit),
    .txd(txd)
`ifdef RISC16_UART_IRQ_EN
    ,
    .irq(irq)
`endif
  );
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic wr(input logic [15:0] a, input logic [1:0] we, input logic [15:0] dat);
    d_addr = a;
    d_we = we;
    d_dout = dat;
    @(negedge clk);
    d_we = 2'b00;
  endtask
  task automatic rd_chk(input string name, input logic [15:0] a, input logic [15:0] exp);
    d_addr = a;
    #1 chk(name, rdata, exp);
  endtask
  // entered on the negedge of the first start-bit cycle; returns on the negedge after the frame
  task automatic tx_frame(input logic [7:0] b, input int div, input bit cb, input string name);
    logic e;
    for (int c = 0; c < 10 * div; c++) begin
      e = (c < div) ? 1'b0 : (c < 9 * div) ? b[3'(c / div - 1)] : 1'b1;
      chk($sformatf("%s_txd_c%0d", name, c), {15'b0, txd}, {15'b0, e});
      if (cb) chk($sformatf("%s_busy_c%0d", name, c), {15'b0, rdata[ST_BUSY]}, 16'h0001);
      @(negedge clk);
    end
  endtask
  initial begin
    vecs[0]  = '{16'hFF02, 2'b00, 16'h0000, 16'h0001, 1'b1};
    vecs[1]  = '{16'hFF00, 2'b00, 16'h0000, 16'h0000, 1'b1};
    vecs[2]  = '{16'hFF04, 2'b00, 16'h0000, 16'h01B2, 1'b1};
    vecs[3]  = '{16'hFF04, 2'b11, 16'h1234, 16'h1234, 1'b1};
    vecs[4]  = '{16'hFF04, 2'b01, 16'hAB00, 16'hAB34, 1'b1};
    vecs[5]  = '{16'hFF04, 2'b10, 16'h00CD, 16'hABCD, 1'b1};
    vecs[6]  = '{16'hFF06, 2'b11, 16'hFFFF, CTRL_EXP, 1'b1};
    vecs[7]  = '{16'hFF02, 2'b11, 16'hFFFF, 16'h0001, 1'b1};
    vecs[8]  = '{16'hFEFE, 2'b00, 16'h0000, 16'h0000, 1'b0};
    vecs[9]  = '{16'hFF08, 2'b00, 16'h0000, 16'h0000, 1'b0};
    vecs[10] = '{16'hFF07, 2'b00, 16'h0000, CTRL_EXP, 1'b1};
    vecs[11] = '{16'hFF05, 2'b11, 16'h0004, 16'h0004, 1'b1};
    @(negedge clk);
    #1 chk("rst_txd", {15'b0, txd}, 16'h0001);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rel_txd", {15'b0, txd}, 16'h0001);
`ifdef RISC16_UART_IRQ_EN
    chk("rel_irq", {15'b0, irq}, 16'h0000);
`endif
    rd_chk("rel_status", 16'hFF02, 16'h0001);
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      d_addr = vecs[i].addr;
      d_dout = vecs[i].dout;
      d_we = vecs[i].we;
      if (vecs[i].we != 2'b00) begin
        @(negedge clk);
        d_we = 2'b00;
      end
      #1 chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp);
      chk($sformatf("vec%0d_hit", i), {15'b0, hit}, {15'b0, vecs[i].exp_hit});
      @(negedge clk);
    end
    wr(16'hFF00, 2'b11, 16'h0055);
    d_addr = 16'hFF02;
    #1 chk("lat_idle", {15'b0, txd}, 16'h0001);
    @(negedge clk);
    tx_frame(8'h55, 4, 1'b1, "f55");
    rd_chk("f55_done", 16'hFF02, 16'h0001);
    wr(16'hFF00, 2'b01, 16'hA300);
    d_addr = 16'hFF02;
    @(negedge clk);
    tx_frame(8'hA3, 4, 1'b1, "fa3");
    rd_chk("fa3_done", 16'hFF02, 16'h0001);
    fork
      begin
        for (int i = 1; i <= 10; i++) begin
          d_addr = 16'hFF00;
          d_we = 2'b11;
          d_dout = 16'(i);
          @(negedge clk);
        end
        d_we = 2'b00;
        d_addr = 16'hFF02;
        #1 chk("burst_status", rdata, 16'h080E);
      end
      begin
        @(negedge clk);
        @(negedge clk);
        for (int k = 1; k <= 9; k++) tx_frame(8'(k), 4, 1'b0, $sformatf("burst%0d", k));
      end
    join
    rd_chk("burst_done", 16'hFF02, 16'h0009);
    chk("burst_idle_txd", {15'b0, txd}, 16'h0001);
    wr(16'hFF02, 2'b11, 16'h0000);
    rd_chk("ovf_clear", 16'hFF02, 16'h0001);
    wr(16'hFF04, 2'b11, 16'h0000);
    rd_chk("div0_rd", 16'hFF04, 16'h0000);
    wr(16'hFF00, 2'b11, 16'h00FF);
    d_addr = 16'hFF02;
    @(negedge clk);
    tx_frame(8'hFF, 1, 1'b1, "div0");
    rd_chk("div0_done", 16'hFF02, 16'h0001);
    wr(16'hFF04, 2'b11, 16'h0004);
    wr(16'hFF00, 2'b11, 16'h0055);
    @(negedge clk);
    repeat (17) @(negedge clk);
    #1 chk("mid_bit3_txd", {15'b0, txd}, 16'h0000);
    #1 rst = 1'b1;
    #1 chk("rst_async_txd", {15'b0, txd}, 16'h0001);
    @(negedge clk);
    rst = 1'b0;
    rd_chk("rst2_status", 16'hFF02, 16'h0001);
    rd_chk("rst2_div", 16'hFF04, 16'h01B2);
    chk("rst2_txd", {15'b0, txd}, 16'h0001);
    repeat (3) @(negedge clk);
    chk("rst2_txd_hold", {15'b0, txd}, 16'h0001);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
